// File: rtl/ysyx_23060136_exu_div_ctrl.sv
// Requester-side controller for the EXU iterative divider. Handles div-by-zero and overflow locally, and issues other ops to the divider.
// Results are ready 1 cycle after accept (special) or after div_out_valid. It holds div_valid/res_valid until div_ready/res_ready; flush aborts, draining a busy divider.
module ysyx_23060136_exu_div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_sel,
    input  logic        op_w,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] result,
    output logic [63:0] dividend,
    output logic [63:0] divisor,
    output logic        div_valid,
    output logic        divw,
    output logic        div_signed,
    input  logic        div_ready,
    input  logic        div_out_valid,
    input  logic [63:0] quotient,
    input  logic [63:0] remainder
);

    localparam int ysyx_23060136_BITS_W = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_e;

    state_e                          state_q, state_d;
    logic                            rem_q, rem_d;
    logic                            w_q, w_d;
    logic [ysyx_23060136_BITS_W-1:0] dividend_q, dividend_d;
    logic [ysyx_23060136_BITS_W-1:0] divisor_q, divisor_d;
    logic                            divw_q, divw_d;
    logic                            div_signed_q, div_signed_d;
    logic [ysyx_23060136_BITS_W-1:0] result_q, result_d;
    logic                            div_valid_q;
    logic                            res_valid_q;

    logic                            accept;
    logic                            op_sgn;
    logic [ysyx_23060136_BITS_W-1:0] opa, opb;
    logic                            div_zero, div_ovf;

    function automatic logic [63:0] pick_res(input logic rem, input logic w,
                                             input logic [63:0] q, input logic [63:0] r);
        logic [63:0] sel;
        sel = rem ? r : q;
        return w ? {{32{sel[31]}}, sel[31:0]} : sel;
    endfunction

    assign op_ready   = (state_q == S_IDLE);
    assign res_valid  = res_valid_q;
    assign result     = result_q;
    assign div_valid  = div_valid_q;
    assign dividend   = dividend_q;
    assign divisor    = divisor_q;
    assign divw       = divw_q;
    assign div_signed = div_signed_q;

    always_comb begin
        accept = op_valid && (state_q == S_IDLE) && !flush;
        op_sgn = ~op_sel[0];
        if (op_w) begin
            opa = op_sgn ? {{32{src1[31]}}, src1[31:0]} : {32'b0, src1[31:0]};
            opb = op_sgn ? {{32{src2[31]}}, src2[31:0]} : {32'b0, src2[31:0]};
        end else begin
            opa = src1;
            opb = src2;
        end
        div_zero = (opb == '0);
        // W operands are already sign-extended, so the low word alone identifies INT32_MIN / -1.
        div_ovf  = op_sgn && (op_w ? (opa[31:0] == 32'h8000_0000 && opb[31:0] == 32'hFFFF_FFFF)
                                   : (opa == {1'b1, 63'b0} && opb == '1));
    end

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        w_d          = w_q;
        dividend_d   = dividend_q;
        divisor_d    = divisor_q;
        divw_d       = divw_q;
        div_signed_d = div_signed_q;
        result_d     = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (div_zero) begin
                        result_d = pick_res(op_sel[1], op_w, '1, opa);
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = pick_res(op_sel[1], op_w, opa, '0);
                        state_d  = S_DONE;
                    end else begin
                        rem_d        = op_sel[1];
                        w_d          = op_w;
                        dividend_d   = opa;
                        divisor_d    = opb;
                        divw_d       = op_w;
                        div_signed_d = op_sgn;
                        state_d      = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (div_ready) begin
                    state_d = flush ? S_DRAIN : S_WAIT;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (div_out_valid) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        result_d = pick_res(rem_q, w_q, quotient, remainder);
                        state_d  = S_DONE;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                if (flush || res_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (div_out_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rem_q        <= 1'b0;
            w_q          <= 1'b0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            divw_q       <= 1'b0;
            div_signed_q <= 1'b0;
            result_q     <= '0;
            div_valid_q  <= 1'b0;
            res_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            w_q          <= w_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
            divw_q       <= divw_d;
            div_signed_q <= div_signed_d;
            result_q     <= result_d;
            div_valid_q  <= (state_d == S_ISSUE);
            res_valid_q  <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_ysyx_23060136_exu_div_ctrl.sv
// Directed bench for the divider controller with a behavioural divider and a result scoreboard.
`timescale 1ns/1ps
module tb_ysyx_23060136_exu_div_ctrl;

    logic        clk = 1'b0;
    logic        rst, flush, op_valid, op_ready, op_w;
    logic [1:0]  op_sel;
    logic [63:0] src1, src2, result, dividend, divisor, quotient, remainder;
    logic        res_valid, res_ready, div_valid, divw, div_signed, div_ready, div_out_valid;

    always #5 clk = ~clk;

    ysyx_23060136_exu_div_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op_ready(op_ready),
        .op_sel(op_sel), .op_w(op_w), .src1(src1), .src2(src2),
        .res_valid(res_valid), .res_ready(res_ready), .result(result),
        .dividend(dividend), .divisor(divisor), .div_valid(div_valid), .divw(divw),
        .div_signed(div_signed), .div_ready(div_ready), .div_out_valid(div_out_valid),
        .quotient(quotient), .remainder(remainder)
    );

    typedef struct {
        logic [63:0] res;
        bit          special;
        int          acc;
    } exp_t;
    exp_t sb[$];

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // divider model knobs and state
    int          rdy_delay = 0, lat = 0, stall = 0, lcnt = 0, dov_cyc = -10, req_cnt = 0;
    bit          busy = 0;
    logic [63:0] m_q = '0, m_r = '0, pend_q = '0, pend_r = '0;
    int          rr_delay = 0, dcnt = 0, dv_cycles = 0;

    // expected divider request operands
    bit          exp_ops = 0;
    logic [63:0] e_dvd = '0, e_dvs = '0;
    logic        e_w = 0, e_s = 0;

    // monitor history
    bit          prv_rv = 0, prv_rr = 0, prv_dv = 0, prv_dr = 0;
    logic [63:0] prv_res = '0, prv_dvd = '0, prv_dvs = '0;
    logic        prv_w = 0, prv_s = 0;
    exp_t        mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        div_ready = 0; div_out_valid = 0; quotient = '0; remainder = '0;
        forever begin
            @(posedge clk); #1;
            div_ready = 0; div_out_valid = 0;
            if (rst) begin
                busy = 0; stall = 0;
            end else if (busy) begin
                if (lcnt == 0) begin
                    div_out_valid = 1; quotient = pend_q; remainder = pend_r;
                    busy = 0; dov_cyc = cyc;
                end else lcnt--;
            end else if (div_valid) begin
                if (stall >= rdy_delay) begin
                    div_ready = 1; stall = 0; busy = 1; lcnt = lat;
                    pend_q = m_q; pend_r = m_r; req_cnt++;
                end else stall++;
            end else stall = 0;
        end
    end

    initial begin
        res_ready = 1;
        forever begin
            @(posedge clk); #1;
            if (res_valid && dcnt < rr_delay) begin
                res_ready = 0; dcnt++;
            end else begin
                res_ready = 1;
                if (!res_valid) dcnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (div_valid) dv_cycles++;
                if (div_valid && prv_dv && !prv_dr) begin
                    chk("dividend_stable", dividend, prv_dvd);
                    chk("divisor_stable", divisor, prv_dvs);
                    chk("mode_stable", {62'b0, divw, div_signed}, {62'b0, prv_w, prv_s});
                end
                if (div_valid && div_ready && exp_ops) begin
                    chk("req_dividend", dividend, e_dvd);
                    chk("req_divisor", divisor, e_dvs);
                    chk("req_mode", {62'b0, divw, div_signed}, {62'b0, e_w, e_s});
                end
                if (res_valid) begin
                    chk("op_ready_in_done", op_ready, 0);
                    if (!prv_rv && sb.size() > 0)
                        chk("res_latency", 64'(cyc), 64'(sb[0].special ? sb[0].acc + 1 : dov_cyc + 1));
                    if (prv_rv && prv_rr) begin
                        checks++; failures++;
                        $display("FAIL dup_result: res_valid still high after transfer, result %h", result);
                    end else if (prv_rv) chk("result_stable", result, prv_res);
                    if (res_ready) begin
                        if (sb.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL unexpected_result: got %h with no op pending", result);
                        end else begin
                            mon_e = sb.pop_front();
                            chk("result", result, mon_e.res);
                        end
                    end
                end
            end
            prv_rv = res_valid; prv_rr = res_ready; prv_res = result;
            prv_dv = div_valid; prv_dr = div_ready; prv_dvd = dividend; prv_dvs = divisor;
            prv_w = divw; prv_s = div_signed;
        end
    end

    task automatic issue_op(input logic [1:0] sel, input logic w, input logic [63:0] a,
                            input logic [63:0] b, input logic [63:0] q, input logic [63:0] r,
                            input int rdly, input int l, input logic [63:0] exp_res,
                            input bit special, input logic [63:0] edvd, input logic [63:0] edvs);
        int   t;
        int   dv0;
        exp_t e;
        m_q = q; m_r = r; rdy_delay = rdly; lat = l;
        exp_ops = !special; e_dvd = edvd; e_dvs = edvs; e_w = w; e_s = ~sel[0];
        op_sel = sel; op_w = w; src1 = a; src2 = b; op_valid = 1;
        t = 0;
        while (!op_ready && t < 100) begin tick(); t++; end
        if (!op_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout: op_ready %b required 1", op_ready);
            op_valid = 0;
            return;
        end
        dv0 = dv_cycles;
        e.res = exp_res; e.special = special; e.acc = cyc;
        sb.push_back(e);
        tick();
        op_valid = 0;
        t = 0;
        while ((sb.size() != 0 || !op_ready) && t < 200) begin tick(); t++; end
        if (sb.size() != 0 || !op_ready) begin
            checks++; failures++;
            $display("FAIL done_timeout: pending %0d required 0", sb.size());
            sb.delete();
        end
        if (special) chk("no_div_request", 64'(dv_cycles), 64'(dv0));
        exp_ops = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t;
        bit  drained;
        rst = 1; flush = 0; op_valid = 0; op_sel = 2'b00; op_w = 0; src1 = '0; src2 = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_div_valid", div_valid, 0);
        chk("rst_dividend", dividend, 0);
        chk("rst_divisor", divisor, 0);
        chk("rst_mode", {62'b0, divw, div_signed}, 0);
        rst = 0;
        tick();
        chk("post_rst_op_ready", op_ready, 1);

        // DIVU / REMU 100 / 7
        issue_op(2'b01, 0, 64'd100, 64'd7, 64'd14, 64'd2, 0, 10, 64'd14, 0, 64'd100, 64'd7);
        issue_op(2'b11, 0, 64'd100, 64'd7, 64'd14, 64'd2, 0, 10, 64'd2, 0, 64'd100, 64'd7);
        // W signed overflow, 64-bit overflow, divide-by-zero variants
        issue_op(2'b00, 1, 64'hFFFF_FFFF_8000_0000, '1, '0, '0, 0, 0, 64'hFFFF_FFFF_8000_0000, 1, '0, '0);
        issue_op(2'b10, 1, 64'hFFFF_FFFF_8000_0000, '1, '0, '0, 0, 0, 64'h0, 1, '0, '0);
        issue_op(2'b10, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0, '0, '0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF9, 1, '0, '0);
        issue_op(2'b01, 0, 64'd100, 64'h0, '0, '0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, '0, '0);
        issue_op(2'b00, 0, 64'h8000_0000_0000_0000, '1, '0, '0, 0, 0, 64'h8000_0000_0000_0000, 1, '0, '0);
        issue_op(2'b10, 1, 64'h0000_0001_8000_0005, 64'h0000_0001_0000_0000, '0, '0, 0, 0,
                 64'hFFFF_FFFF_8000_0005, 1, '0, '0);
        // unsigned view of the overflow pattern goes to the divider
        issue_op(2'b01, 0, 64'h8000_0000_0000_0000, '1, 64'h0, 64'h8000_0000_0000_0000, 1, 2,
                 64'h0, 0, 64'h8000_0000_0000_0000, '1);
        // DIV -20 / 3 with div_ready held low 5 cycles
        issue_op(2'b00, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA,
                 64'hFFFF_FFFF_FFFF_FFFE, 5, 3, 64'hFFFF_FFFF_FFFF_FFFA, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
        // DIVW -16 / 3: operands sign-extended, quotient low word sign-extended
        issue_op(2'b00, 1, 64'h1234_5678_FFFF_FFF0, 64'hABCD_0000_0000_0003, 64'h0000_0000_FFFF_FFFB,
                 64'h0, 0, 4, 64'hFFFF_FFFF_FFFF_FFFB, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd3);
        // DIVUW: operands zero-extended
        issue_op(2'b01, 1, 64'hFFFF_FFFF_8000_0000, 64'd1, 64'h0000_0000_8000_0000, 64'h0, 0, 2,
                 64'hFFFF_FFFF_8000_0000, 0, 64'h0000_0000_8000_0000, 64'd1);
        // writeback stalls 4 cycles
        rr_delay = 4;
        issue_op(2'b11, 0, 64'd100, 64'd7, 64'd14, 64'd2, 0, 3, 64'd2, 0, 64'd100, 64'd7);
        rr_delay = 0;

        // flush in IDLE cancels the accept
        op_sel = 2'b01; op_w = 0; src1 = 64'd5; src2 = 64'd0; op_valid = 1; flush = 1;
        tick();
        op_valid = 0; flush = 0;
        chk("idle_flush_no_result", res_valid, 0);
        tick();
        chk("idle_flush_op_ready", op_ready, 1);

        // flush in DONE drops the result
        rr_delay = 10;
        op_valid = 1;
        tick();
        op_valid = 0;
        chk("done_before_flush", res_valid, 1);
        flush = 1;
        tick();
        flush = 0;
        chk("done_flush_res_valid", res_valid, 0);
        chk("done_flush_op_ready", op_ready, 1);
        rr_delay = 0;
        tick();

        // flush in WAIT: stale quotient must be drained, never presented
        m_q = 64'hDEAD_BEEF_DEAD_BEEF; m_r = 64'hDEAD; rdy_delay = 0; lat = 6;
        op_sel = 2'b01; op_w = 0; src1 = 64'd100; src2 = 64'd7; op_valid = 1;
        tick();
        op_valid = 0;
        tick();
        chk("wait_div_valid_low", div_valid, 0);
        flush = 1; op_valid = 1; op_sel = 2'b00; src1 = 64'hFFFF_FFFF_FFFF_FFEC; src2 = 64'd3;
        tick();
        flush = 0;
        chk("drain_op_ready", op_ready, 0);
        t = 0; drained = 0;
        while (!op_ready && t < 50) begin
            if (div_out_valid) drained = 1;
            tick(); t++;
        end
        chk("drain_saw_stale", drained, 1);
        chk("drain_release", op_ready, 1);
        issue_op(2'b00, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA,
                 64'hFFFF_FFFF_FFFF_FFFE, 0, 5, 64'hFFFF_FFFF_FFFF_FFFA, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3);

        repeat (3) tick();
        chk("final_queue_empty", 64'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
